neosd_dat_tx: RTL

Write-direction DAT-line engine of the SD host: takes a byte stream for one data block and serialises it onto DAT0 (1-bit mode) or DAT[3:0] (4-bit mode) as start bit, payload, per-line CRC16 and end bit. It then releases the bus, captures the card's 3-bit CRC status token and waits out the card's busy signal. It sits between the block byte FIFO and the SD pads. It instantiates one `neosd_dat_crc` per DAT line.

---
 rtl/neosd_pkg.sv | 26 ++
 rtl/neosd_dat_tx_if.sv | 9 +
 rtl/neosd_dat_crc.sv | 27 ++
 rtl/neosd_dat_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/neosd_pkg.sv
// Shared definitions for the SD host DAT-line engines: FSM states, status
// tokens and error flag positions.
package neosd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_SWAIT,
    ST_STATUS,
    ST_BUSY,
    ST_FLUSH
  } dat_tx_state_t;

  localparam logic [2:0] SD_TOK_OK  = 3'b010;
  localparam logic [2:0] SD_TOK_CRC = 3'b101;
  localparam logic [2:0] SD_TOK_WR  = 3'b110;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_BADTOK   = 1;
  localparam int ERR_STATTO   = 2;
  localparam int ERR_BUSYTO   = 3;

endpackage

// File: rtl/neosd_dat_tx_if.sv
// Byte-stream handshake between the block FIFO and the DAT write engine.
interface neosd_dat_tx_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;

  modport master (output tx_data_i, tx_valid_i, input tx_ready_o);
  modport slave  (input tx_data_i, tx_valid_i, output tx_ready_o);
endinterface

// File: rtl/neosd_dat_crc.sv
// Per-line CRC16 (x^16+x^12+x^5+1, zero init). In output mode it shifts its
// remainder out MSB first and zero-fills, so it ends at zero after 16 shifts.
module neosd_dat_crc (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic shift_s_i,
  input  logic output_s_i,
  input  logic data_s_i,
  output logic data_s_o,
  output logic nonzero_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = {crc_q[14:0], 1'b0};
    if (!output_s_i && (data_s_i ^ crc_q[15])) crc_d = crc_d ^ 16'h1021;
    data_s_o  = crc_q[15];
    nonzero_o = |crc_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)        crc_q <= '0;
    else if (shift_s_i) crc_q <= crc_d;
  end

endmodule

// File: rtl/neosd_dat_tx.sv
// SD host write-direction DAT engine: start bit, payload, per-line CRC16, end
// bit, then CRC status token capture and busy wait.
module neosd_dat_tx import neosd_pkg::*; #(
  parameter int BLOCK_BYTES    = 512,
  parameter int STATUS_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT   = 1048575
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clkstrb_i,
  input  logic                 start_i,
  input  logic                 wide_i,
  input  logic                 abort_i,
  neosd_dat_tx_if.slave        tx_if,
  output logic [3:0]           sd_dat_o,
  output logic [3:0]           sd_dat_oe_o,
  input  logic [3:0]           sd_dat_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2:0]           crc_status_o,
  output logic [3:0]           error_o
);

  localparam int CNT_MAX = (8 * BLOCK_BYTES > BUSY_TIMEOUT) ? 8 * BLOCK_BYTES : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  dat_tx_state_t state_q;
  logic             wide_q, hold_v_q, done_q;
  logic [7:0]       sh_q, hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       dat_q, oe_q, err_q;
  logic [2:0]       stat_q;

  logic [3:0] act, drv_bits, crc_shift, crc_dout, crc_nz;
  logic [7:0] next_byte;
  logic       byte_end, crc_out, dat_hi_unused;

  always_comb begin
    act       = wide_q ? 4'hF : 4'h1;
    drv_bits  = wide_q ? sh_q[7:4] : {3'b111, sh_q[7]};
    next_byte = hold_v_q ? hold_q : 8'h00;
    // the down-counter doubles as bit position: low bits hit zero on each byte's last strobe
    byte_end  = wide_q ? (cnt_q[0] == 1'b0) : (cnt_q[2:0] == 3'd0);
    crc_shift = '0;
    crc_out   = 1'b0;
    if (clkstrb_i) begin
      case (state_q)
        ST_DATA:  crc_shift = act;
        ST_CRC:   begin crc_shift = act; crc_out = 1'b1; end
        ST_FLUSH: begin crc_shift = {4{|crc_nz}}; crc_out = 1'b1; end
        default:  ;
      endcase
    end
    dat_hi_unused = ^sd_dat_i[3:1];
  end

  for (genvar g = 0; g < 4; g++) begin : g_crc
    neosd_dat_crc u_crc (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .shift_s_i  (crc_shift[g]),
      .output_s_i (crc_out),
      .data_s_i   (drv_bits[g]),
      .data_s_o   (crc_dout[g]),
      .nonzero_o  (crc_nz[g])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      wide_q   <= 1'b0;
      hold_v_q <= 1'b0;
      hold_q   <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      dat_q    <= '1;
      oe_q     <= '0;
      err_q    <= '0;
      stat_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && state_q != ST_IDLE && state_q != ST_FLUSH) begin
        state_q  <= ST_FLUSH;
        oe_q     <= '0;
        dat_q    <= '1;
        hold_v_q <= 1'b0;
        cnt_q    <= CNT_W'(15);
      end else begin
        case (state_q)
          ST_IDLE: if (start_i && !abort_i) begin
            wide_q  <= wide_i;
            err_q   <= '0;
            state_q <= ST_START;
          end
          ST_START: if (clkstrb_i) begin
            dat_q    <= ~act;
            oe_q     <= act;
            sh_q     <= next_byte;
            hold_v_q <= 1'b0;
            if (!hold_v_q) err_q[ERR_UNDERRUN] <= 1'b1;
            cnt_q    <= wide_q ? CNT_W'(2 * BLOCK_BYTES - 1) : CNT_W'(8 * BLOCK_BYTES - 1);
            state_q  <= ST_DATA;
          end
          ST_DATA: if (clkstrb_i) begin
            dat_q <= drv_bits;
            if (cnt_q == '0) begin
              state_q <= ST_CRC;
              cnt_q   <= CNT_W'(15);
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
              if (byte_end) begin
                sh_q     <= next_byte;
                hold_v_q <= 1'b0;
                if (!hold_v_q) err_q[ERR_UNDERRUN] <= 1'b1;
              end else begin
                sh_q <= wide_q ? {sh_q[3:0], 4'h0} : {sh_q[6:0], 1'b0};
              end
            end
          end
          ST_CRC: if (clkstrb_i) begin
            dat_q <= crc_dout | ~act;
            if (cnt_q == '0) state_q <= ST_END;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end
          ST_END: if (clkstrb_i) begin
            dat_q   <= '1;
            state_q <= ST_SWAIT;
            cnt_q   <= CNT_W'(STATUS_TIMEOUT - 1);
          end
          ST_SWAIT: if (clkstrb_i) begin
            oe_q <= '0;
            if (cnt_q <= CNT_W'(STATUS_TIMEOUT - 3) && !sd_dat_i[0]) begin
              state_q <= ST_STATUS;
              cnt_q   <= CNT_W'(3);
            end else if (cnt_q == '0) begin
              err_q[ERR_STATTO] <= 1'b1;
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_STATUS: if (clkstrb_i) begin
            if (cnt_q != '0) begin
              stat_q <= {stat_q[1:0], sd_dat_i[0]};
              cnt_q  <= cnt_q - CNT_W'(1);
            end else begin
              if (stat_q != SD_TOK_OK) err_q[ERR_BADTOK] <= 1'b1;
              state_q <= ST_BUSY;
              cnt_q   <= CNT_W'(BUSY_TIMEOUT - 1);
            end
          end
          ST_BUSY: if (clkstrb_i) begin
            if (sd_dat_i[0]) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else if (cnt_q == '0) begin
              err_q[ERR_BUSYTO] <= 1'b1;
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          ST_FLUSH: if (clkstrb_i) begin
            if (!(|crc_nz) || cnt_q == '0) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: state_q <= ST_IDLE;
        endcase
        // accepted after the case so a byte arriving on an underrun load is kept
        if (tx_if.tx_valid_i && !hold_v_q) begin
          hold_q   <= tx_if.tx_data_i;
          hold_v_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    sd_dat_o         = dat_q;
    sd_dat_oe_o      = oe_q;
    busy_o           = (state_q != ST_IDLE);
    done_o           = done_q;
    crc_status_o     = stat_q;
    error_o          = err_q;
    tx_if.tx_ready_o = ~hold_v_q;
  end

endmodule
